exe_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
- Latches the 149-bit decode-to-execute bus and computes the ALU result.
- Issues lw/sw requests to the data SRAM through a request/addr_ok handshake, then forwards results to the MEM stage.
- Exports its destination-register state to the bypass and stall units.

---
 rtl/exe_stage.sv | 115 +++++++++++
 tb/tb_exe_stage.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/exe_stage.sv
// MIPS execute stage: latches the decode bus, computes the ALU result and issues
// lw/sw requests to the data SRAM through a req/addr_ok handshake.
module exe_stage #(
  parameter int ID_TO_EXE_BUS_WD  = 149,
  parameter int EXE_TO_MEM_BUS_WD = 73,
  parameter int EXE_TO_BY_BUS_WD  = 40
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [ID_TO_EXE_BUS_WD-1:0]  ID_to_EXE_bus,
  input  logic                         ID_to_EXE_valid,
  output logic                         EXE_allow_in,
  input  logic                         MEM_allow_in,
  output logic                         EXE_to_MEM_valid,
  output logic [EXE_TO_MEM_BUS_WD-1:0] EXE_to_MEM_bus,
  output logic [EXE_TO_BY_BUS_WD-1:0]  EXE_to_BY_bus,
  output logic                         data_sram_req,
  output logic                         data_sram_wr,
  output logic [31:0]                  data_sram_addr,
  output logic [31:0]                  data_sram_wdata,
  input  logic                         data_sram_addr_ok
);

  typedef enum logic {IDLE = 1'b0, SENT = 1'b1} state_e;

  state_e                        state_q, state_d;
  logic                          exe_valid_q;
  logic [ID_TO_EXE_BUS_WD-1:0]   bus_q;

  logic        src1_sel, src2_sel, ram_w_en, rf_w_en, mem_gene, mem_op, ready_go;
  logic [3:0]  alu_op;
  logic [1:0]  rf_w_data_sel;
  logic [31:0] pc_plus_4, rdata1, rdata2, imm, src1, src2, alu_result;
  logic [4:0]  sa, w_addr, shamt;

  assign src1_sel      = bus_q[148];
  assign src2_sel      = bus_q[147];
  assign alu_op        = bus_q[146:143];
  assign ram_w_en      = bus_q[142];
  assign rf_w_data_sel = bus_q[141:140];
  assign rf_w_en       = bus_q[139];
  assign mem_gene      = bus_q[138];
  assign pc_plus_4     = bus_q[137:106];
  assign rdata1        = bus_q[105:74];
  assign rdata2        = bus_q[73:42];
  assign sa            = bus_q[41:37];
  assign imm           = bus_q[36:5];
  assign w_addr        = bus_q[4:0];

  assign src1   = src1_sel ? rdata1 : {27'b0, sa};
  assign src2   = src2_sel ? imm : rdata2;
  assign shamt  = src1[4:0];
  assign mem_op = ram_w_en | mem_gene;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      4'b0000: alu_result = src1 + src2;
      4'b0001: alu_result = src1 - src2;
      4'b0010: alu_result = {31'b0, $signed(src1) < $signed(src2)};
      4'b0011: alu_result = {31'b0, src1 < src2};
      4'b0100: alu_result = src1 & src2;
      4'b0101: alu_result = ~(src1 | src2);
      4'b0110: alu_result = src1 | src2;
      4'b0111: alu_result = src1 ^ src2;
      4'b1000: alu_result = src2 << shamt;
      4'b1001: alu_result = src2 >> shamt;
      4'b1010: alu_result = $unsigned($signed(src2) >>> shamt);
      4'b1011: alu_result = {src2[15:0], 16'b0};
      default: alu_result = '0;
    endcase
  end

  // Memory FSM: SENT remembers an accepted request whose instruction is still
  // waiting for MEM, so the SRAM never sees a duplicate.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (data_sram_req && data_sram_addr_ok && !MEM_allow_in) state_d = SENT;
      SENT: if (MEM_allow_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_sram_req = 1'b0;
    data_sram_wr  = ram_w_en;
    if (state_q == IDLE) data_sram_req = exe_valid_q & mem_op;
  end

  assign ready_go         = ~mem_op | (state_q == SENT) | (data_sram_req & data_sram_addr_ok);
  assign EXE_allow_in     = ~exe_valid_q | (ready_go & MEM_allow_in);
  assign EXE_to_MEM_valid = exe_valid_q & ready_go;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exe_valid_q <= 1'b0;
      bus_q       <= '0;
    end else if (EXE_allow_in) begin
      exe_valid_q <= ID_to_EXE_valid;
      if (ID_to_EXE_valid) bus_q <= ID_to_EXE_bus;
    end
  end

  assign data_sram_addr  = alu_result;
  assign data_sram_wdata = rdata2;
  assign EXE_to_MEM_bus  = {rf_w_data_sel, rf_w_en, mem_gene, pc_plus_4, alu_result, w_addr};
  assign EXE_to_BY_bus   = {exe_valid_q, rf_w_en, mem_gene, w_addr, alu_result};

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU ops, SRAM handshake, SENT state, async reset.
module tb_exe_stage;

  logic         clk;
  logic         reset;
  logic [148:0] id_bus;
  logic         id_valid;
  logic         exe_allow_in;
  logic         mem_allow_in;
  logic         to_mem_valid;
  logic [72:0]  to_mem_bus;
  logic [39:0]  to_by_bus;
  logic         req, wr, addr_ok;
  logic [31:0]  addr, wdata;

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;

  exe_stage dut (
    .clk               (clk),
    .reset             (reset),
    .ID_to_EXE_bus     (id_bus),
    .ID_to_EXE_valid   (id_valid),
    .EXE_allow_in      (exe_allow_in),
    .MEM_allow_in      (mem_allow_in),
    .EXE_to_MEM_valid  (to_mem_valid),
    .EXE_to_MEM_bus    (to_mem_bus),
    .EXE_to_BY_bus     (to_by_bus),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_addr    (addr),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset && req && addr_ok) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [72:0] got, input logic [72:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [148:0] mk_bus(
    input logic s1, input logic s2, input logic [3:0] op, input logic wen,
    input logic [1:0] wds, input logic rfw, input logic mg, input logic [31:0] pc4,
    input logic [31:0] rd1, input logic [31:0] rd2, input logic [4:0] sa,
    input logic [31:0] imm, input logic [4:0] wa);
    return {s1, s2, op, wen, wds, rfw, mg, pc4, rd1, rd2, sa, imm, wa};
  endfunction

  // Operands rdata1=F0F01234, rdata2=0FF01111 (shamt = 0x14 = 20)
  logic [31:0] alu_exp [16] = '{
    32'h00E02345, 32'hE1000123, 32'h00000001, 32'h00000000,
    32'h00F01010, 32'h000FECCA, 32'hFFF01335, 32'hFF000325,
    32'h11100000, 32'h000000FF, 32'h000000FF, 32'h11110000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};

  initial begin
    reset = 1'b0; id_bus = '0; id_valid = 1'b0; mem_allow_in = 1'b1; addr_ok = 1'b0;
    #2;
    chk("rst_allow_in", exe_allow_in, 1'b1);
    chk("rst_to_mem_valid", to_mem_valid, 1'b0);
    chk("rst_req", req, 1'b0);
    chk("rst_mem_bus", to_mem_bus, '0);
    chk("rst_by_bus", to_by_bus, '0);
    #1 reset = 1'b1;

    // addu wraps
    id_bus = mk_bus(1, 0, 4'b0000, 0, 2'b00, 1, 0, 32'h00400004, 32'hFFFFFFFF, 32'h2, 5'd0, 32'h0, 5'd3);
    id_valid = 1'b1;
    tick();
    chk("addu_bus", to_mem_bus, {2'b00, 1'b1, 1'b0, 32'h00400004, 32'h00000001, 5'd3});
    chk("addu_valid", to_mem_valid, 1'b1);
    chk("addu_req", req, 1'b0);
    chk("addu_allow_in", exe_allow_in, 1'b1);

    // sra / srl by sa
    id_bus = mk_bus(0, 0, 4'b1010, 0, 2'b00, 1, 0, 32'h0, 32'h0, 32'h80000000, 5'd4, 32'h0, 5'd1);
    tick();
    chk("sra", to_mem_bus[36:5], 32'hF8000000);
    id_bus = mk_bus(0, 0, 4'b1001, 0, 2'b00, 1, 0, 32'h0, 32'h0, 32'h80000000, 5'd4, 32'h0, 5'd1);
    tick();
    chk("srl", to_mem_bus[36:5], 32'h08000000);

    // every alu_op, streamed back to back
    for (int i = 0; i < 16; i++) begin
      id_bus = mk_bus(1, 0, 4'(i), 0, 2'b00, 1, 0, 32'h0, 32'hF0F01234, 32'h0FF01111, 5'd0, 32'h0, 5'd2);
      tick();
      chk($sformatf("alu_op_%0d", i), to_mem_bus[36:5], alu_exp[i]);
    end

    // sw with addr_ok delayed three cycles; an addu waits behind it
    id_bus = mk_bus(1, 1, 4'b0000, 1, 2'b00, 0, 0, 32'h0, 32'h100, 32'hDEADBEEF, 5'd0, 32'h8, 5'd0);
    tick();
    id_bus = mk_bus(1, 0, 4'b0000, 0, 2'b00, 1, 0, 32'h0, 32'h3, 32'h4, 5'd0, 32'h0, 5'd7);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("sw_req_%0d", k), {req, wr}, 2'b11);
      chk($sformatf("sw_addr_%0d", k), addr, 32'h108);
      chk($sformatf("sw_wdata_%0d", k), wdata, 32'hDEADBEEF);
      chk($sformatf("sw_allow_in_%0d", k), exe_allow_in, 1'b0);
      chk($sformatf("sw_valid_%0d", k), to_mem_valid, 1'b0);
      tick();
    end
    addr_ok = 1'b1;
    #1;
    chk("sw_ok_req", {req, wr}, 2'b11);
    chk("sw_ok_wdata", wdata, 32'hDEADBEEF);
    chk("sw_ok_allow_in", exe_allow_in, 1'b1);
    chk("sw_ok_valid", to_mem_valid, 1'b1);
    tick();
    addr_ok = 1'b0;
    #1;
    chk("after_sw_alu", to_mem_bus[36:5], 32'h7);
    chk("after_sw_req", req, 1'b0);
    chk("sw_accept_cnt", acc_cnt, 1);

    // lw accepted while MEM stalls -> SENT, then leaves when MEM frees up
    id_bus = mk_bus(1, 1, 4'b0000, 0, 2'b01, 1, 1, 32'h0, 32'h200, 32'h0, 5'd0, 32'h4, 5'd5);
    tick();
    id_bus = mk_bus(1, 1, 4'b0000, 0, 2'b00, 1, 0, 32'h0, 32'd10, 32'h0, 5'd0, 32'hFFFFFFFF, 5'd9);
    mem_allow_in = 1'b0;
    addr_ok = 1'b1;
    #1;
    chk("lw_req", {req, wr}, 2'b10);
    chk("lw_addr", addr, 32'h204);
    chk("lw_by_bus", to_by_bus, {1'b1, 1'b1, 1'b1, 5'd5, 32'h204});
    chk("lw_valid", to_mem_valid, 1'b1);
    chk("lw_allow_in", exe_allow_in, 1'b0);
    tick();
    chk("sent1_req", req, 1'b0);
    chk("sent1_valid", to_mem_valid, 1'b1);
    chk("sent1_allow_in", exe_allow_in, 1'b0);
    chk("sent1_alu", to_mem_bus[36:5], 32'h204);
    tick();
    chk("sent2_req", req, 1'b0);
    chk("sent2_valid", to_mem_valid, 1'b1);
    mem_allow_in = 1'b1;
    #1;
    chk("sent2_allow_in", exe_allow_in, 1'b1);
    tick();
    addr_ok = 1'b0;
    #1;
    chk("addiu_alu", to_mem_bus[36:5], 32'd9);
    chk("addiu_valid", to_mem_valid, 1'b1);
    chk("addiu_req", req, 1'b0);
    chk("lw_accept_cnt", acc_cnt, 2);

    // slt / sltu on the same operands
    id_bus = mk_bus(1, 0, 4'b0010, 0, 2'b00, 1, 0, 32'h0, 32'hFFFFFFFE, 32'h1, 5'd0, 32'h0, 5'd4);
    tick();
    chk("slt", to_mem_bus[36:5], 32'h1);
    id_bus = mk_bus(1, 0, 4'b0011, 0, 2'b00, 1, 0, 32'h0, 32'hFFFFFFFE, 32'h1, 5'd0, 32'h0, 5'd4);
    tick();
    chk("sltu", to_mem_bus[36:5], 32'h0);

    // reset while a sw waits for addr_ok
    id_bus = mk_bus(1, 1, 4'b0000, 1, 2'b00, 0, 0, 32'h0, 32'h300, 32'h12345678, 5'd0, 32'h0, 5'd0);
    tick();
    id_valid = 1'b0;
    #1;
    chk("rstmid_req_before", req, 1'b1);
    #1 reset = 1'b0;
    #1;
    chk("rstmid_req", req, 1'b0);
    chk("rstmid_allow_in", exe_allow_in, 1'b1);
    chk("rstmid_valid", to_by_bus[39], 1'b0);
    #2 reset = 1'b1;
    tick();
    chk("rstpost_req", req, 1'b0);
    chk("rstpost_valid", to_mem_valid, 1'b0);
    chk("rstpost_by_valid", to_by_bus[39], 1'b0);
    chk("rstpost_mem_bus", to_mem_bus, '0);
    chk("rstpost_accept_cnt", acc_cnt, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
